// File: rtl/shared_cmp_arbiter_pkg.sv
// Shared definitions for the two-requester compare/arithmetic arbiter.
package shared_cmp_arbiter_pkg;

    localparam int WIDTH = 24;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/shared_cmp_arbiter_cmp_unit.sv
// Combinational add/sub/compare unit on a ripple-carry adder.
module shared_cmp_arbiter_cmp_unit
    import shared_cmp_arbiter_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [1:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o,
    output logic         flag_o
);

    logic [W-1:0] b_eff;
    logic [W-1:0] sum;
    logic [W:0]   carry;
    logic         cout;
    logic         ovf;
    logic         lt_s;

    always_comb begin
        b_eff    = (op_i == OP_ADD) ? b_i : ~b_i;
        sum      = '0;
        carry    = '0;
        carry[0] = (op_i != OP_ADD);
        for (int i = 0; i < W; i++) begin
            sum[i]     = a_i[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_eff[i]) | (carry[i] & (a_i[i] ^ b_eff[i]));
        end
    end

    // Signed less-than must fold in overflow, not just the difference sign.
    assign cout = carry[W];
    assign ovf  = (a_i[W-1] == b_eff[W-1]) & (sum[W-1] != a_i[W-1]);
    assign lt_s = sum[W-1] ^ ovf;

    always_comb begin
        result_o = sum;
        flag_o   = cout;
        unique case (op_i)
            OP_ADD, OP_SUB: begin
                result_o = sum;
                flag_o   = cout;
            end
            OP_SLT: begin
                result_o = {{(W-1){1'b0}}, lt_s};
                flag_o   = lt_s;
            end
            OP_SLTU: begin
                result_o = {{(W-1){1'b0}}, ~cout};
                flag_o   = ~cout;
            end
        endcase
    end

endmodule

// File: rtl/shared_cmp_arbiter.sv
// Round-robin arbiter sharing one compare unit between two requesters,
// with a single registered response slot.
module shared_cmp_arbiter
    import shared_cmp_arbiter_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [1:0]   req0_op_i,
    input  logic [W-1:0] req0_a_i,
    input  logic [W-1:0] req0_b_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [1:0]   req1_op_i,
    input  logic [W-1:0] req1_a_i,
    input  logic [W-1:0] req1_b_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [W-1:0] rsp_data_o,
    output logic         rsp_flag_o
);

    state_e       state_q;
    logic         valid_q;
    logic         id_q;
    logic         flag_q;
    logic         ptr_q;
    logic [W-1:0] data_q;

    logic         both_v;
    logic         grant_id;
    logic         can_accept;
    logic         accept;
    logic [1:0]   op_d;
    logic [W-1:0] a_d;
    logic [W-1:0] b_d;
    logic [W-1:0] data_d;
    logic         flag_d;

    assign both_v     = req0_valid_i & req1_valid_i;
    assign grant_id   = both_v ? ptr_q : req1_valid_i;
    assign can_accept = ~rst_i & ((state_q == ST_EMPTY) | (valid_q & rsp_ready_i));

    assign req0_ready_o = can_accept & req0_valid_i & ~grant_id;
    assign req1_ready_o = can_accept & req1_valid_i & grant_id;
    assign accept       = req0_ready_o | req1_ready_o;

    assign op_d = grant_id ? req1_op_i : req0_op_i;
    assign a_d  = grant_id ? req1_a_i  : req0_a_i;
    assign b_d  = grant_id ? req1_b_i  : req0_b_i;

    shared_cmp_arbiter_cmp_unit #(.W(W)) u_cmp (
        .op_i     (op_d),
        .a_i      (a_d),
        .b_i      (b_d),
        .result_o (data_d),
        .flag_o   (flag_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            ptr_q   <= 1'b0;
        end else if (accept) begin
            // A drain on this edge is implied: the slot is reloaded.
            state_q <= ST_FULL;
            valid_q <= 1'b1;
            id_q    <= grant_id;
            data_q  <= data_d;
            flag_q  <= flag_d;
            if (both_v) begin
                ptr_q <= ~grant_id;
            end
        end else if (state_q == ST_FULL && rsp_ready_i) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = data_q;
    assign rsp_flag_o  = flag_q;

endmodule
